io_ram: RTL

- Memory-mapped data RAM plus character I/O port on the processor sysbus, covering the upper part of the 5-bit address space (20..31).
- Sits beside the program ROM (addresses 0..19) and consumes the same bus controls from the sequencer.
- Address map:
  - 20..29: read/write scratch RAM (loop counters).
  - 30: input character port, buffered in a small FIFO.
  - 31: output display register with a valid/ready handshake.

---
 rtl/io_ram_pkg.sv | 26 ++
 rtl/io_in_fifo.sv | 54 +++++
 rtl/io_ram.sv | 123 ++++++++++++
 3 files changed

// File: rtl/io_ram_pkg.sv
// Shared constants, address regions and the address decoder for the
// io_ram data RAM / character I/O block on the processor sysbus.
package io_ram_pkg;

  localparam int unsigned RAM_BASE  = 20;
  localparam int unsigned RAM_WORDS = 10;
  localparam int unsigned IN_ADDR   = 30;
  localparam int unsigned OUT_ADDR  = 31;
  localparam int unsigned RAM_IDX_W = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IN,
    REG_OUT
  } region_e;

  // Everything below RAM_BASE belongs to the program ROM beside us.
  function automatic region_e decode_region(input int unsigned addr);
    if (addr == OUT_ADDR) return REG_OUT;
    if (addr == IN_ADDR)  return REG_IN;
    if (addr >= RAM_BASE && addr < RAM_BASE + RAM_WORDS) return REG_RAM;
    return REG_ROM;
  endfunction

endpackage

// File: rtl/io_in_fifo.sv
// Small circular FIFO buffering input characters until the processor
// reads them from the input port address.
module io_in_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_ram.sv
// Data RAM (20..29), input character port (30) and output display
// register (31) sharing the sysbus with the program ROM.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. in_valid/in_data are sampled only when in_ready is high;
// out_valid stays high with out_data stable until out_ready accepts it.
module io_ram
  import io_ram_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int OP_W     = 3,
  parameter int IN_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MDR_bus,
  input  logic              load_MDR,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int AW = WORD_W - OP_W;

  logic [AW-1:0]        mar;
  logic [WORD_W-1:0]    mdr;
  logic [WORD_W-1:0]    rdata;
  logic [WORD_W-1:0]    ram [RAM_WORDS];
  logic [RAM_IDX_W-1:0] ram_idx;
  region_e              region;
  logic                 sel;
  logic                 rd_en;
  logic                 wr_en;
  logic                 out_xfer;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [WORD_W-1:0]    fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign region  = decode_region(32'(mar));
  assign sel     = (region != REG_ROM);
  assign ram_idx = RAM_IDX_W'(mar - AW'(RAM_BASE));

  // A concurrent load_MDR wins over a read, so such a read never pops.
  assign rd_en    = CS & R_NW & sel & ~load_MDR;
  assign wr_en    = CS & ~R_NW & sel;
  assign out_xfer = out_valid & out_ready;

  assign sysbus = (MDR_bus && sel) ? mdr : 'z;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign fifo_pop  = rd_en && (region == REG_IN) && !fifo_empty;

  io_in_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM: rdata = ram[ram_idx];
      REG_IN:  rdata = fifo_empty ? '0 : fifo_head;
      REG_OUT: rdata = out_data;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (load_MAR) mar <= sysbus[AW-1:0];
      if (load_MDR)   mdr <= sysbus;
      else if (rd_en) mdr <= rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
    end else if (wr_en && region == REG_RAM) begin
      ram[ram_idx] <= mdr;
    end
  end

  // A new display write during a transfer replaces the accepted word
  // cleanly; only writing over an unaccepted word raises overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (wr_en && region == REG_OUT) begin
      out_data  <= mdr;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
